// File: rtl/approx_arith_pkg.sv
// Shared definitions for the approximate-arithmetic characterisation monitors.
// Holds the default widths used by the monitors and the state encoding of the
// statistics-clear sequencer.
package approx_arith_pkg;

    // Default operand width of the adders under characterisation.
    localparam int WIDTH_DEF = 16;
    // Default width of the sample and error counters.
    localparam int CNT_W_DEF = 32;
    // Default width of the sum-of-error-distance accumulator.
    localparam int ACC_W_DEF = 48;

    // RUN   : accepting samples.
    // DRAIN : clear requested, waiting for in-flight samples to retire.
    // ZERO  : one cycle in which all statistics are zeroed.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ZERO  = 2'd2
    } mon_state_t;

endpackage

// File: rtl/approx_err_distance.sv
// Combinational error-distance unit, shared by the adder and multiplier
// monitors.
// Ports:
//   exact      in  W  reference (exact) result
//   approx     in  W  approximate result under test
//   ed         out W  |exact - approx|, unsigned
//   ed_nonzero out 1  high when the two results differ
module approx_err_distance #(
    parameter int W = 17
) (
    input  logic [W-1:0] exact,
    input  logic [W-1:0] approx,
    output logic [W-1:0] ed,
    output logic         ed_nonzero
);

    // Either operand may be the larger one: an approximate adder can
    // over-estimate as well as under-estimate the sum.
    always_comb begin
        if (exact >= approx) begin
            ed = exact - approx;
        end else begin
            ed = approx - exact;
        end
    end

    assign ed_nonzero = (exact != approx);

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Streaming error-metric collector placed after an approximate adder.
// Each handshaken sample {add1, add2, result} is compared with the exact sum;
// the error distance (ED) is reported per sample and folded into saturating
// statistics (sample count, error count, max ED, sum of ED).
// Ports:
//   clk_i         in  1        clock, rising edge
//   rst_i         in  1        asynchronous active-high reset
//   valid_i       in  1        sample valid
//   ready_o       out 1        monitor accepts a sample this cycle
//   add1_i        in  WIDTH    operand 1 driven to the adder
//   add2_i        in  WIDTH    operand 2 driven to the adder
//   result_i      in  WIDTH+1  approximate adder result
//   clear_i       in  1        request to zero all statistics (pulse)
//   ed_valid_o    out 1        ed_o valid for one cycle
//   ed_o          out WIDTH+1  error distance of the retired sample
//   sample_cnt_o  out CNT_W    samples retired since the last clear
//   err_cnt_o     out CNT_W    samples with non-zero ED
//   max_ed_o      out WIDTH+1  largest ED since the last clear
//   sum_ed_o      out ACC_W    sum of ED since the last clear
//   sat_o         out 1        sticky saturation flag
module approx_adder_error_monitor
    import approx_arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [WIDTH:0]   result_i,
    input  logic             clear_i,
    output logic             ed_valid_o,
    output logic [WIDTH:0]   ed_o,
    output logic [CNT_W-1:0] sample_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [WIDTH:0]   max_ed_o,
    output logic [ACC_W-1:0] sum_ed_o,
    output logic             sat_o
);

    localparam int RW = WIDTH + 1;

    mon_state_t state_reg, state_next;

    // Stage 1 registers
    logic          s1_valid_reg;
    logic [RW-1:0] s1_exact_reg;
    logic [RW-1:0] s1_approx_reg;

    // Stage 2 / statistics registers
    logic             ed_valid_reg;
    logic [RW-1:0]    ed_reg;
    logic [CNT_W-1:0] sample_cnt_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    logic [RW-1:0]    max_ed_reg;
    logic [ACC_W-1:0] sum_ed_reg;
    logic             sat_reg;

    logic          accept;
    logic [RW-1:0] ed;
    logic          ed_nz;

    // One extra bit on each sum so the carry-out flags saturation.
    logic [CNT_W:0] sample_ext;
    logic [CNT_W:0] err_ext;
    logic [ACC_W:0] sum_ext;

    assign ready_o = (state_reg == RUN);
    assign accept  = valid_i & ready_o;

    approx_err_distance #(
        .W (RW)
    ) u_err_distance (
        .exact      (s1_exact_reg),
        .approx     (s1_approx_reg),
        .ed         (ed),
        .ed_nonzero (ed_nz)
    );

    assign sample_ext = {1'b0, sample_cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
    assign err_ext    = {1'b0, err_cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
    assign sum_ext    = {1'b0, sum_ed_reg} + {1'b0, ACC_W'(ed)};

    // Stage 2 retires in the same edge that consumes S1, so S1 is the only
    // place a sample can still be in flight once clear has been taken.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (clear_i) state_next = DRAIN;
            DRAIN:   if (!s1_valid_reg) state_next = ZERO;
            ZERO:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= RUN;
            s1_valid_reg   <= 1'b0;
            s1_exact_reg   <= '0;
            s1_approx_reg  <= '0;
            ed_valid_reg   <= 1'b0;
            ed_reg         <= '0;
            sample_cnt_reg <= '0;
            err_cnt_reg    <= '0;
            max_ed_reg     <= '0;
            sum_ed_reg     <= '0;
            sat_reg        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            s1_valid_reg <= accept;
            if (accept) begin
                s1_exact_reg  <= {1'b0, add1_i} + {1'b0, add2_i};
                s1_approx_reg <= result_i;
            end

            ed_valid_reg <= s1_valid_reg;

            if (state_reg == ZERO) begin
                // Pipeline is empty here, so nothing retires this cycle.
                sample_cnt_reg <= '0;
                err_cnt_reg    <= '0;
                max_ed_reg     <= '0;
                sum_ed_reg     <= '0;
                sat_reg        <= 1'b0;
            end else if (s1_valid_reg) begin
                ed_reg <= ed;

                if (sample_ext[CNT_W]) begin
                    sample_cnt_reg <= '1;
                end else begin
                    sample_cnt_reg <= sample_ext[CNT_W-1:0];
                end

                if (ed_nz) begin
                    if (err_ext[CNT_W]) begin
                        err_cnt_reg <= '1;
                    end else begin
                        err_cnt_reg <= err_ext[CNT_W-1:0];
                    end
                end

                if (ed > max_ed_reg) begin
                    max_ed_reg <= ed;
                end

                if (sum_ext[ACC_W]) begin
                    sum_ed_reg <= '1;
                end else begin
                    sum_ed_reg <= sum_ext[ACC_W-1:0];
                end

                if (sample_ext[CNT_W] || (ed_nz && err_ext[CNT_W]) || sum_ext[ACC_W]) begin
                    sat_reg <= 1'b1;
                end
            end
        end
    end

    assign ed_valid_o   = ed_valid_reg;
    assign ed_o         = ed_reg;
    assign sample_cnt_o = sample_cnt_reg;
    assign err_cnt_o    = err_cnt_reg;
    assign max_ed_o     = max_ed_reg;
    assign sum_ed_o     = sum_ed_reg;
    assign sat_o        = sat_reg;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Directed bench for approx_adder_error_monitor: a default-width instance for
// the functional cases and a CNT_W=4 instance for counter saturation.
module tb_approx_adder_error_monitor;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        clear;
    logic [15:0] add1;
    logic [15:0] add2;
    logic [16:0] result;

    logic        ready, ed_valid, sat;
    logic [16:0] ed, max_ed;
    logic [31:0] sample_cnt, err_cnt;
    logic [47:0] sum_ed;

    logic        ready4, ed_valid4, sat4;
    logic [16:0] ed4, max_ed4;
    logic [3:0]  sample_cnt4, err_cnt4;
    logic [47:0] sum_ed4;

    int n_cmp = 0;
    int n_err = 0;

    approx_adder_error_monitor dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid),
        .ready_o      (ready),
        .add1_i       (add1),
        .add2_i       (add2),
        .result_i     (result),
        .clear_i      (clear),
        .ed_valid_o   (ed_valid),
        .ed_o         (ed),
        .sample_cnt_o (sample_cnt),
        .err_cnt_o    (err_cnt),
        .max_ed_o     (max_ed),
        .sum_ed_o     (sum_ed),
        .sat_o        (sat)
    );

    approx_adder_error_monitor #(
        .CNT_W (4)
    ) dut4 (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid),
        .ready_o      (ready4),
        .add1_i       (add1),
        .add2_i       (add2),
        .result_i     (result),
        .clear_i      (clear),
        .ed_valid_o   (ed_valid4),
        .ed_o         (ed4),
        .sample_cnt_o (sample_cnt4),
        .err_cnt_o    (err_cnt4),
        .max_ed_o     (max_ed4),
        .sum_ed_o     (sum_ed4),
        .sat_o        (sat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [15:0] a, input logic [15:0] b, input logic [16:0] r);
        add1   = a;
        add2   = b;
        result = r;
        $display("txn add1=%h add2=%h result=%h", a, b, r);
    endtask

    task automatic do_reset();
        valid = 1'b0;
        clear = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; clear = 1'b0;
        add1 = '0; add2 = '0; result = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_ready", ready, 1);
        check("rst_ed_valid", ed_valid, 0);
        check("rst_ed", ed, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_max_ed", max_ed, 0);
        check("rst_sum_ed", sum_ed, 0);
        check("rst_sat", sat, 0);

        // Single erroneous sample, latency 2: A3CA vs 093BA -> ED 1010
        sample(16'h29AF, 16'h7A1B, 17'h093BA);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("t1_ed_valid_early", ed_valid, 0);
        tick();
        check("t1_ed_valid", ed_valid, 1);
        check("t1_ed", ed, 17'h01010);
        check("t1_sample_cnt", sample_cnt, 1);
        check("t1_err_cnt", err_cnt, 1);
        check("t1_max_ed", max_ed, 17'h01010);
        check("t1_sum_ed", sum_ed, 48'h1010);

        // Back-to-back samples: ED 0, 0010, 0
        do_reset();
        valid = 1'b1;
        sample(16'h0000, 16'h1234, 17'h01234);
        tick();
        sample(16'h8051, 16'h8086, 17'h100C7);
        tick();
        sample(16'h1111, 16'hEEAA, 17'h0FFBB);
        tick();
        valid = 1'b0;
        tick();
        check("t2_ed_valid", ed_valid, 1);
        check("t2_ed_last", ed, 0);
        check("t2_sample_cnt", sample_cnt, 3);
        check("t2_err_cnt", err_cnt, 1);
        check("t2_max_ed", max_ed, 17'h00010);
        check("t2_sum_ed", sum_ed, 48'h10);

        // Clear together with an accepted sample whose result exceeds exact (ED 5)
        sample(16'h0001, 16'h0002, 17'h00008);
        valid = 1'b1;
        clear = 1'b1;
        tick();
        valid = 1'b0;
        clear = 1'b0;
        check("t3_ready_c1", ready, 0);
        check("t3_ed_valid_c1", ed_valid, 0);
        tick();
        check("t3_ready_c2", ready, 0);
        check("t3_ed_valid_c2", ed_valid, 1);
        check("t3_ed", ed, 17'h00005);
        check("t3_sample_cnt_preclear", sample_cnt, 4);
        check("t3_err_cnt_preclear", err_cnt, 2);
        check("t3_sum_ed_preclear", sum_ed, 48'h15);
        tick();
        check("t3_ready_c3", ready, 0);
        check("t3_ed_valid_c3", ed_valid, 0);
        tick();
        check("t3_ready_after", ready, 1);
        check("t3_sample_cnt", sample_cnt, 0);
        check("t3_err_cnt", err_cnt, 0);
        check("t3_max_ed", max_ed, 0);
        check("t3_sum_ed", sum_ed, 0);
        check("t3_sat", sat, 0);

        // Asynchronous reset while draining
        sample(16'h0010, 16'h0020, 17'h00031);
        valid = 1'b1;
        tick();
        sample(16'h0040, 16'h0050, 17'h00093);
        clear = 1'b1;
        tick();
        valid = 1'b0;
        clear = 1'b0;
        check("t5_ready_drain", ready, 0);
        check("t5_sample_cnt_pre", sample_cnt, 1);
        #4;
        rst = 1'b1;
        #1;
        check("t5_async_ready", ready, 1);
        check("t5_async_ed_valid", ed_valid, 0);
        check("t5_async_ed", ed, 0);
        check("t5_async_sample_cnt", sample_cnt, 0);
        check("t5_async_sum_ed", sum_ed, 0);
        check("t5_async_max_ed", max_ed, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_pulse", ed_valid, 0);
        end
        check("t5_sample_cnt_post", sample_cnt, 0);

        // valid held high through DRAIN and ZERO
        do_reset();
        sample(16'h0100, 16'h0200, 17'h00300);
        valid = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t6_ready_c1", ready, 0);
        tick();
        check("t6_ready_c2", ready, 0);
        check("t6_sample_cnt_preclear", sample_cnt, 1);
        tick();
        check("t6_ready_c3", ready, 0);
        tick();
        check("t6_ready_run", ready, 1);
        check("t6_sample_cnt_zeroed", sample_cnt, 0);
        tick();
        tick();
        tick();
        valid = 1'b0;
        tick();
        check("t6_sample_cnt", sample_cnt, 3);
        check("t6_err_cnt", err_cnt, 0);

        // CNT_W=4 saturation
        do_reset();
        sample(16'h0001, 16'h0001, 17'h00002);
        valid = 1'b1;
        repeat (16) tick();
        valid = 1'b0;
        tick();
        check("t4_cnt4_sat", sample_cnt4, 4'hF);
        check("t4_sat4", sat4, 1);
        check("t4_err_cnt4", err_cnt4, 0);
        check("t4_wide_cnt", sample_cnt, 16);
        check("t4_wide_sat", sat, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        check("t4_ready4_zero", ready4, 0);
        tick();
        check("t4_ready4_run", ready4, 1);
        check("t4_cnt4_cleared", sample_cnt4, 0);
        check("t4_sat4_cleared", sat4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
